// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame parser: default parameters,
// FSM state encoding, abort cause codes and a small width helper.
package uart_frame_pkg;

    localparam logic [7:0] DEFAULT_SYNC_BYTE      = 8'hA5;
    localparam int         DEFAULT_MAX_LEN        = 16;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        PAYLOAD = 3'd2,
        CHK     = 3'd3,
        EMIT    = 3'd4
    } parserState_t;

    typedef enum logic [1:0] {
        ERR_TIMEOUT = 2'd0,
        ERR_BAD_LEN = 2'd1,
        ERR_BAD_CHK = 2'd2,
        ERR_LINE    = 2'd3
    } errCode_t;

    // Address width needed to index a memory of the given depth (at least 1 bit).
    function automatic int addrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: DEPTH x 8 bits, one synchronous write
// port and one combinational read port. Contents are deliberately not
// reset; every location read during EMIT was written earlier in the frame.
module uart_frame_buf #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [7:0]        i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [7:0]        o_rdData
);

    logic [7:0] r_mem [DEPTH];

    // Capture a payload byte on the rising edge when the parser writes.
    always_ff @(posedge clock) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/uart_frame_parser.sv
// UART frame parser: hunts for SYNC_BYTE, reads a length byte, buffers the
// payload while summing it, verifies the checksum and then replays the
// payload on a valid/ready output stream. Line errors, bad lengths, bad
// checksums and inter-byte timeouts abort the frame with a one-cycle pulse.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         MAX_LEN        = DEFAULT_MAX_LEN,
    parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] io_in_bits,
    input  logic       io_in_valid,
    output logic       io_in_ready,
    input  logic       io_in_error,
    output logic [7:0] io_out_bits,
    output logic       io_out_valid,
    input  logic       io_out_ready,
    output logic       io_out_last,
    output logic       io_frame_ok,
    output logic       io_frame_err,
    output logic [1:0] io_err_code
);

    localparam int                 CNT_W       = $clog2(MAX_LEN + 1);
    localparam int                 BUF_AW      = addrWidth(MAX_LEN);
    localparam int                 TMR_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]         MAX_LEN_B   = 8'(MAX_LEN);
    localparam logic [TMR_W-1:0]   TIMEOUT_VAL = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [TMR_W-1:0]   TMR_ONE     = TMR_W'(1);

    parserState_t       r_state;
    parserState_t       w_nextState;
    logic               r_active;
    logic [CNT_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_idx;
    logic [7:0]         r_sum;
    logic [TMR_W-1:0]   r_timer;
    logic               r_frameOk;
    logic               r_frameErr;
    logic [1:0]         r_errCode;

    logic               w_accept;
    logic               w_inFrame;
    logic               w_lineErr;
    logic               w_timeout;
    logic               w_byte;
    logic               w_lenOk;
    logic               w_lastIdx;
    logic               w_outFire;
    logic               w_abort;
    errCode_t           w_abortCode;
    logic               w_frameGood;
    logic               w_bufWe;
    logic [BUF_AW-1:0]  w_bufAddr;
    logic [7:0]         w_rdData;

    // r_active holds io_in_ready low while reset is asserted and until the
    // first clock edge afterwards, so the upstream never sees a stale ready.
    assign io_in_ready  = r_active && (r_state != EMIT);
    assign w_accept     = io_in_valid && io_in_ready;
    assign w_inFrame    = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CHK);
    assign w_lineErr    = w_inFrame && io_in_error;
    assign w_timeout    = w_inFrame && (r_timer == TIMEOUT_VAL);
    // A byte only counts when no abort condition coincides with it.
    assign w_byte       = w_accept && !w_lineErr && !w_timeout;
    assign w_lenOk      = (io_in_bits != 8'd0) && (io_in_bits <= MAX_LEN_B);
    assign w_lastIdx    = (r_idx == (r_len - CNT_ONE));

    assign io_out_valid = (r_state == EMIT);
    assign io_out_bits  = io_out_valid ? w_rdData : 8'h00;
    assign io_out_last  = io_out_valid && w_lastIdx;
    assign w_outFire    = io_out_valid && io_out_ready;

    assign io_frame_ok  = r_frameOk;
    assign io_frame_err = r_frameErr;
    assign io_err_code  = r_errCode;

    // The same index walks the buffer for writes in PAYLOAD and reads in EMIT.
    assign w_bufAddr    = r_idx[BUF_AW-1:0];
    assign w_bufWe      = (r_state == PAYLOAD) && w_byte;

    uart_frame_buf #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (BUF_AW)
    ) u_buf (
        .clock    (clock),
        .i_wrEn   (w_bufWe),
        .i_wrAddr (w_bufAddr),
        .i_wrData (io_in_bits),
        .i_rdAddr (w_bufAddr),
        .o_rdData (w_rdData)
    );

    // State register; reset drops the parser back to hunting for a sync byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_active <= 1'b1;
        end
    end

    // Next-state decode: line error beats timeout, timeout beats a new byte.
    always_comb begin
        w_nextState = r_state;
        w_abort     = 1'b0;
        w_abortCode = ERR_TIMEOUT;
        w_frameGood = 1'b0;

        if (w_lineErr) begin
            w_abort     = 1'b1;
            w_abortCode = ERR_LINE;
        end else if (w_timeout) begin
            w_abort     = 1'b1;
            w_abortCode = ERR_TIMEOUT;
        end

        unique case (r_state)
            IDLE: begin
                if (w_accept && (io_in_bits == SYNC_BYTE)) begin
                    w_nextState = LEN;
                end
            end
            LEN: begin
                if (w_byte) begin
                    if (w_lenOk) begin
                        w_nextState = PAYLOAD;
                    end else begin
                        w_abort     = 1'b1;
                        w_abortCode = ERR_BAD_LEN;
                    end
                end
            end
            PAYLOAD: begin
                if (w_byte && w_lastIdx) begin
                    w_nextState = CHK;
                end
            end
            CHK: begin
                if (w_byte) begin
                    if (io_in_bits == r_sum) begin
                        w_nextState = EMIT;
                        w_frameGood = 1'b1;
                    end else begin
                        w_abort     = 1'b1;
                        w_abortCode = ERR_BAD_CHK;
                    end
                end
            end
            EMIT: begin
                if (w_outFire && w_lastIdx) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase

        if (w_abort) begin
            w_nextState = IDLE;
        end
    end

    // Length, running checksum and buffer index bookkeeping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_len <= '0;
            r_idx <= '0;
            r_sum <= 8'h00;
        end else begin
            unique case (r_state)
                LEN: begin
                    if (w_byte && w_lenOk) begin
                        r_len <= io_in_bits[CNT_W-1:0];
                        r_sum <= io_in_bits;
                        r_idx <= '0;
                    end
                end
                PAYLOAD: begin
                    if (w_byte) begin
                        r_sum <= r_sum + io_in_bits;
                        r_idx <= r_idx + CNT_ONE;
                    end
                end
                CHK: begin
                    if (w_frameGood) begin
                        r_idx <= '0;
                    end
                end
                EMIT: begin
                    if (w_outFire && !w_lastIdx) begin
                        r_idx <= r_idx + CNT_ONE;
                    end
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    // Inter-byte timer: counts idle cycles mid-frame, cleared by any byte.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_timer <= '0;
        end else if (w_inFrame && !w_accept && !w_abort) begin
            r_timer <= r_timer + TMR_ONE;
        end else begin
            r_timer <= '0;
        end
    end

    // One-cycle status pulses reporting frame success or abort cause.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_frameOk  <= 1'b0;
            r_frameErr <= 1'b0;
            r_errCode  <= 2'b00;
        end else begin
            r_frameOk  <= w_frameGood;
            r_frameErr <= w_abort;
            r_errCode  <= w_abort ? w_abortCode : 2'b00;
        end
    end

endmodule

// File: doc/uart_frame_parser.md
UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

Interface
REQ-001 SHALL have parameter SYNC_BYTE, 8'hA5, the start-of-frame marker.
REQ-002 SHALL have parameter MAX_LEN, 16, the maximum payload length in bytes.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 1024, the inter-byte timeout.
REQ-004 SHALL have port clock  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-006 SHALL have port io_in_bits  input  8  received byte from the UART RX channel.
REQ-007 SHALL have port io_in_valid  input  1  io_in_bits is valid.
REQ-008 SHALL have port io_in_ready  output  1  parser accepts a byte.
REQ-009 SHALL have port io_in_error  input  1  UART RX line/framing error pulse.
REQ-010 SHALL have port io_out_bits  output  8  payload byte.
REQ-011 SHALL have port io_out_valid  output  1  io_out_bits is valid.
REQ-012 SHALL have port io_out_ready  input  1  consumer accepts the payload byte.
REQ-013 SHALL have port io_out_last  output  1  marks the final payload byte of the frame.
REQ-014 SHALL have port io_frame_ok  output  1  one-cycle pulse when a frame passes its checksum.
REQ-015 SHALL have port io_frame_err  output  1  one-cycle pulse when a frame is aborted.
REQ-016 SHALL have port io_err_code  output  2  abort cause, valid with io_frame_err: 0 timeout, 1 bad length, 2 bad checksum, 3 line error.

Function
REQ-017 A frame SHALL be SYNC_BYTE, LEN, LEN payload bytes, CHK, where CHK = (LEN + sum of payload bytes) mod 256.
REQ-018 A byte SHALL be accepted only in a cycle where io_in_valid and io_in_ready are both high.
REQ-019 The state machine SHALL have states IDLE, LEN, PAYLOAD, CHK and EMIT.
REQ-020 IDLE: an accepted SYNC_BYTE SHALL move to LEN; any other accepted byte SHALL be discarded silently.
REQ-021 LEN: an accepted byte in 1..MAX_LEN SHALL be stored and move to PAYLOAD.
REQ-022 LEN: an accepted byte of 0 or greater than MAX_LEN SHALL abort with code 1.
REQ-023 PAYLOAD: each accepted byte SHALL be written to the buffer at index 0..LEN-1 and added into an 8-bit running sum seeded with LEN.
REQ-024 PAYLOAD: acceptance of byte LEN-1 SHALL move to CHK.
REQ-025 CHK: if the accepted byte equals the running sum, the FSM SHALL move to EMIT and pulse io_frame_ok in the next cycle; otherwise it SHALL abort with code 2.
REQ-026 io_in_ready SHALL be high in IDLE, LEN, PAYLOAD and CHK, and low in EMIT.
REQ-027 EMIT: io_out_valid SHALL be high with io_out_bits = buf[idx], starting the cycle after CHK is accepted.
REQ-028 EMIT: idx SHALL advance only on an out handshake.
REQ-029 EMIT: io_out_last SHALL be high when idx = LEN-1.
REQ-030 EMIT: io_out_bits SHALL be held stable while io_out_ready is low.
REQ-031 EMIT: the last-byte handshake SHALL return the FSM to IDLE, with io_in_ready high in the next cycle.
REQ-032 A timeout counter SHALL clear on every accepted byte and increment each cycle in LEN, PAYLOAD and CHK.
REQ-033 The timeout counter reaching TIMEOUT_CYCLES SHALL abort with code 0; the counter SHALL be idle in IDLE and EMIT.
REQ-034 io_in_error high in LEN, PAYLOAD or CHK SHALL abort with code 3; io_in_error SHALL be ignored in IDLE and EMIT.
REQ-035 If io_in_error and an accepted byte coincide, the error SHALL win and the byte SHALL be dropped.
REQ-036 An abort SHALL pulse io_frame_err for one cycle with io_err_code, return to IDLE next cycle, and produce no io_out_valid.
REQ-037 Running sum SHALL wrap modulo 256; idx and the length counter SHALL be clog2(MAX_LEN+1) bits wide.

Reset
REQ-038 Asserting reset SHALL force IDLE asynchronously at any time, including mid-frame or mid-EMIT.
REQ-039 During reset, io_out_valid, io_out_last, io_frame_ok, io_frame_err, io_err_code and io_out_bits SHALL be 0, and io_in_ready SHALL be 0.
REQ-040 Buffer contents SHALL NOT be reset.

Structure
REQ-041 Package uart_frame_pkg SHALL hold the SYNC_BYTE, MAX_LEN and TIMEOUT_CYCLES defaults, the state enum, and the error-code enum.
REQ-042 The payload store SHALL be sub-module uart_frame_buf: MAX_LEN x 8, one synchronous write port, one combinational read port.

Verification
REQ-043 Send A5 03 11 22 33 69 -> io_frame_ok pulse; out bytes 11, 22, 33; io_out_last only on 33.
REQ-044 Send 00 FF A5 01 7E 7F -> the leading 00 and FF are dropped; single out byte 7E with io_out_last high.
REQ-045 Send A5 02 10 20 00 -> io_frame_err with io_err_code 2; no io_out_valid.
REQ-046 Send A5 00, then separately A5 11 -> io_frame_err code 1 for each.
REQ-047 Send A5 02 01, then idle for TIMEOUT_CYCLES -> io_frame_err code 0; a following valid frame is parsed correctly.
REQ-048 Hold io_out_ready low for 5 cycles during EMIT of A5 03 11 22 33 69 -> io_out_bits stable, io_in_ready 0 throughout; then pulse io_in_error during a PAYLOAD phase -> code 3.
